// File: rtl/fp_add_result_buffer.sv
// Result buffer that sits behind the 5-stage SP adder pipeline, with credit backpressure.
// Optional FP_RESULT_ZERO_FLUSH_EN: results with a zero exponent field are stored as +0.
module fp_add_result_buffer #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  output logic [31:0]                op_a,
  output logic [31:0]                op_b,
  input  logic [31:0]                add_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LATENCY-1:0] tag_q, tag_d;
  logic [31:0]        mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic               accept;
  logic               capture;
  logic               pop;
  logic [31:0]        wr_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign occupancy = inflight_q + count_q;
  assign in_ready  = (occupancy < CW'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign op_a      = accept ? in_a : 32'h0;
  assign op_b      = accept ? in_b : 32'h0;
  assign capture   = tag_q[LATENCY-1];
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign pop       = out_valid & out_ready;

`ifdef FP_RESULT_ZERO_FLUSH_EN
  assign wr_data = (add_result[30:23] == 8'h0) ? 32'h0 : add_result;
`else
  assign wr_data = add_result;
`endif

  // Next-state for tags, pointers and the two credit counters
  always_comb begin
    tag_d      = '0;
    tag_d[0]   = accept;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    wr_ptr_d   = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d    = count_q;
    unique case ({capture, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    inflight_d = inflight_q;
    unique case ({accept, capture})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // Result storage; contents are only meaningful while counted
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Credits must make a capture into a full FIFO impossible
  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset) !(capture && count_q == CW'(DEPTH))
  );

endmodule

// File: tb/tb_fp_add_result_buffer.sv
// Bench for fp_add_result_buffer: behavioural adder, queue-based reference model.
// Honours FP_RESULT_ZERO_FLUSH_EN when defined for the build.
module tb_fp_add_result_buffer;

  localparam int LATENCY = 4;
  localparam int DEPTH   = 8;
  localparam int CW      = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_a = '0;
  logic [31:0]   in_b = '0;
  logic [31:0]   op_a, op_b;
  logic [31:0]   add_result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [CW-1:0] occupancy;
  logic          poison = 1'b0;

  logic [31:0]   pipe [LATENCY];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_acc    = 0;

  typedef struct {
    logic [31:0] val;
    int          t;
  } exp_t;
  exp_t exp_q[$];

  fp_add_result_buffer #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .op_a      (op_a),
    .op_b      (op_b),
    .add_result(add_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'h0) return 0.0;
    d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, b);
    return r2sp(sp2r(a) + sp2r(b));
  endfunction

  function automatic logic [31:0] stored(input logic [31:0] x);
`ifdef FP_RESULT_ZERO_FLUSH_EN
    return (x[30:23] == 8'h0) ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [31:0] rnd_sp();
    return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  // Behavioural adder: fixed latency, poison forces a chosen result pattern
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= poison ? 32'h8000_0001 : fadd(op_a, op_b);
    end
  end
  assign add_result = pipe[LATENCY-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                      input bit r, input bit rst = 1'b0, input bit psn = 1'b0);
    bit m_valid;
    bit m_ready;
    bit acc;
    bit pp;
    @(negedge clk);
    m_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].t + LATENCY + 1);
    m_ready = exp_q.size() < DEPTH;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
    if (m_valid) chk("out_data", out_data, exp_q[0].val);
    reset     = rst;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = r;
    poison    = psn;
    acc = v & m_ready;
    pp  = m_valid & r;
    #1;
    chk("op_a", op_a, acc ? a : 32'h0);
    chk("op_b", op_b, acc ? b : 32'h0);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back('{val: stored(psn ? 32'h8000_0001 : fadd(a, b)), t: cyc});
        n_acc++;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) step(1'b0, 32'h0, 32'h0, r);
  endtask

  initial begin
    int n0;
    repeat (2) @(posedge clk);

    idle(2, 1'b0);

    step(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    idle(3, 1'b0);
    #2;
    chk("single_early", 32'(out_valid), 32'd0);
    idle(1, 1'b0);
    #2;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", out_data, 32'h4040_0000);
    idle(2, 1'b1);

    for (int i = 0; i < 10; i++) begin
      step(1'b1, rnd_sp(), rnd_sp(), 1'b1);
      #2;
      chk("b2b_occ_bound", 32'(occupancy <= CW'(LATENCY + 1)), 32'd1);
    end
    idle(8, 1'b1);

    n0 = n_acc;
    repeat (12) step(1'b1, rnd_sp(), rnd_sp(), 1'b0);
    #2;
    chk("bp_accepts", 32'(n_acc - n0), 32'd8);
    chk("bp_occ", 32'(occupancy), 32'd8);
    chk("bp_ready", 32'(in_ready), 32'd0);
    step(1'b1, rnd_sp(), rnd_sp(), 1'b1);
    #2;
    chk("bp_credit", 32'(in_ready), 32'd1);
    n0 = n_acc;
    repeat (3) step(1'b1, rnd_sp(), rnd_sp(), 1'b0);
    chk("bp_extra", 32'(n_acc - n0), 32'd1);
    idle(12, 1'b1);

    repeat (4) step(1'b1, rnd_sp(), rnd_sp(), 1'b0);
    idle(3, 1'b0);
    idle(1, 1'b1);
    #2;
    chk("cap_pop_occ", 32'(occupancy), 32'd3);
    idle(6, 1'b1);

    repeat (5) step(1'b1, rnd_sp(), rnd_sp(), 1'b0);
    idle(1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #2;
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    idle(10, 1'b1);

    step(1'b1, rnd_sp(), rnd_sp(), 1'b0, 1'b0, 1'b1);
    idle(5, 1'b0);
    #2;
    chk("flush_valid", 32'(out_valid), 32'd1);
`ifdef FP_RESULT_ZERO_FLUSH_EN
    chk("flush_data", out_data, 32'h0000_0000);
`else
    chk("flush_data", out_data, 32'h8000_0001);
`endif
    idle(2, 1'b1);

    repeat (400) begin
      step($urandom_range(0, 3) != 0, rnd_sp(), rnd_sp(), $urandom_range(0, 2) != 0);
    end
    idle(16, 1'b1);
    #2;
    chk("final_occ", 32'(occupancy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_add_result_buffer.md
# fp_add_result_buffer

Downstream companion of the 5-stage IEEE-754 single-precision adder pipeline. It tracks which adder pipeline slots hold real operations, captures the matching adder results into a FIFO, and presents them on a ready/valid output. It issues credit-based backpressure upstream, because the adder pipeline itself cannot stall. Operands enter through this block and are forwarded to the adder; results return from the adder and are buffered here.

## Interface

Parameters:
- LATENCY, default 4: cycles from operand presentation on op_a/op_b to the matching valid adder Result on add_result; legal range ≥1.
- DEPTH, default 8: result FIFO entries; legal range ≥1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  block can accept an operation this cycle.
- in_a  input  32  operand 1, IEEE-754 SP.
- in_b  input  32  operand 2, IEEE-754 SP.
- op_a  output  32  operand 1 to adder Number1.
- op_b  output  32  operand 2 to adder Number2.
- add_result  input  32  adder Result.
- out_valid  output  1  FIFO head holds a result.
- out_ready  input  1  downstream accepts the head.
- out_data  output  32  FIFO head result.
- occupancy  output  $clog2(DEPTH+1)  in-flight operations plus FIFO entries.

## Operation

- accept = in_valid & in_ready.
- op_a/op_b: combinational. Equal to in_a/in_b when accept = 1, else 32'h0, so bubbles enter the adder as zeros.
- Tag pipeline: LATENCY-bit shift register. Bit 0 loads accept each cycle. capture = tag[LATENCY-1], which is high in exactly the cycle add_result belongs to an accepted operation.
- On capture, add_result is written to the FIFO tail. The value is taken as-is, or flushed per Configuration.
- FIFO: circular, DEPTH entries, with wr_ptr/rd_ptr wrapping from DEPTH-1 to 0 and a count register.
- pop = out_valid & out_ready.
- out_valid = (count != 0); out_data = mem[rd_ptr].
- Credits: occupancy = inflight + count.
  - inflight increments on accept and decrements on capture; both in one cycle leaves it unchanged.
  - in_ready = (occupancy < DEPTH), combinational from registers only. It does not depend on in_valid, out_ready, or the current-cycle pop.
- Credits guarantee no overflow: a capture never finds the FIFO full. The implementation carries an assertion (capture & count==DEPTH) → error, checked in simulation only.
- Simultaneous capture and pop with count != 0: both performed, count unchanged.
- Pop with count == 0 cannot occur, since out_valid is low.
- Result ordering is strictly FIFO, identical to accept order.

## Timing

- Reset values:
  - in_ready = 1 (DEPTH ≥ 1).
  - out_valid = 0, out_data = mem[0] (don't-care; benches check it only when out_valid = 1).
  - occupancy = 0.
  - op_a = op_b = 0 whenever in_valid = 0.
  - Tag register, pointers, count and inflight all cleared.
- Latency: accept in cycle t → capture in cycle t+LATENCY → out_valid in cycle t+LATENCY+1 (FIFO write at the t+LATENCY edge).
- Throughput: one operation per cycle, sustained, while out_ready stays high.
- With out_ready held low, exactly DEPTH operations are accepted; in_ready then falls the cycle after the DEPTH-th accept.
- Credit return: a pop in cycle t raises in_ready in cycle t+1. There is no same-cycle pop-to-accept bypass.
- Reset mid-operation: all in-flight tags and buffered results are discarded, with no output afterwards. The adder's own reset must be asserted together with this one.

## Configuration

- FP_RESULT_ZERO_FLUSH_EN defined: on capture, any add_result with exponent field [30:23] == 0 is stored as 32'h0000_0000 (sign and mantissa cleared).
- Not defined: add_result is stored unmodified, including denormal-pattern and -0 values.

## Test plan

- Single op: in_a=32'h3F800000, in_b=32'h40000000, with the adder attached → out_valid first high exactly 5 cycles after accept, out_data=32'h40400000.
- Back-to-back: 10 consecutive accepts with out_ready=1 → 10 results in order, in_ready constantly 1, occupancy ≤ LATENCY+1.
- Backpressure: out_ready=0 with in_valid held high → exactly 8 accepts, then in_ready=0 and occupancy=8. Raising out_ready for one cycle pops one entry, in_ready=1 the next cycle, and exactly one further accept follows.
- Simultaneous capture and pop with count=3 → count stays 3; out_data advances to the next entry in order.
- Reset asserted for one cycle while 3 operations are in flight and 2 are buffered → occupancy=0 and out_valid=0, and no result appears in the following 10 cycles.
- Flush: add_result forced to 32'h8000_0001 on capture → out_data=32'h0 with FP_RESULT_ZERO_FLUSH_EN defined, 32'h8000_0001 without it.
